// File: rtl/register_writeback_queue.sv
// register_writeback_queue: merges pipeline writeback and a FIFO-buffered aux source onto one register file write port.
module register_writeback_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeValid,
  input  logic [4:0]  pipeAddr,
  input  logic [31:0] pipeData,
  input  logic        auxValid,
  output logic        auxReady,
  input  logic [4:0]  auxAddr,
  input  logic [31:0] auxData,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData,
  output logic        wrEnable,
  input  logic [4:0]  q1Addr,
  input  logic [4:0]  q2Addr,
  output logic        q1Busy,
  output logic        q2Busy,
  output logic        orderErr
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]  fifoAddr [DEPTH];
  logic [31:0] fifoData [DEPTH];
  logic [AW:0] rdPtr, wrPtr, count;
  logic [DEPTH-1:0] entryValid;
  logic full, empty, xfer, pipeReq, bypass, push, outAux, pipeHit, q1Hit, q2Hit;
  assign count = wrPtr - rdPtr;
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign auxReady = !full && !rst;
  assign xfer = auxValid && auxReady;
  assign pipeReq = pipeValid && pipeAddr != 5'd0;
  assign bypass = !pipeReq && empty && xfer && auxAddr != 5'd0;
  assign push = xfer && auxAddr != 5'd0 && !bypass;
  always_comb begin
    logic [AW-1:0] off;
    entryValid = '0;
    pipeHit = 1'b0;
    q1Hit = 1'b0;
    q2Hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rdPtr[AW-1:0];
      entryValid[i] = {1'b0, off} < count;
      pipeHit = pipeHit || (entryValid[i] && fifoAddr[i] == pipeAddr);
      q1Hit = q1Hit || (entryValid[i] && fifoAddr[i] == q1Addr);
      q2Hit = q2Hit || (entryValid[i] && fifoAddr[i] == q2Addr);
    end
  end
  // only aux writes sitting on the output stage count as busy; pipe writes are forwarded
  assign q1Busy = q1Addr != 5'd0 && (q1Hit || (wrEnable && outAux && wrAddr == q1Addr));
  assign q2Busy = q2Addr != 5'd0 && (q2Hit || (wrEnable && outAux && wrAddr == q2Addr));
  always_ff @(posedge clk)
    if (push) begin
      fifoAddr[wrPtr[AW-1:0]] <= auxAddr;
      fifoData[wrPtr[AW-1:0]] <= auxData;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      wrEnable <= 1'b0;
      wrAddr <= 5'd0;
      wrData <= RESET;
      outAux <= 1'b0;
      orderErr <= 1'b0;
    end else begin
      wrEnable <= pipeReq || !empty || bypass;
      outAux <= !pipeReq && (!empty || bypass);
      wrAddr <= pipeReq ? pipeAddr : !empty ? fifoAddr[rdPtr[AW-1:0]] : bypass ? auxAddr : wrAddr;
      wrData <= pipeReq ? pipeData : !empty ? fifoData[rdPtr[AW-1:0]] : bypass ? auxData : wrData;
      rdPtr <= (!pipeReq && !empty) ? rdPtr + 1'b1 : rdPtr;
      wrPtr <= push ? wrPtr + 1'b1 : wrPtr;
      orderErr <= orderErr || (pipeReq && pipeHit);
    end
endmodule

// File: tb/tb_register_writeback_queue.sv
// tb_register_writeback_queue: scoreboard bench with a behavioural queue model of the writeback merger.
module tb_register_writeback_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET = 32'hA5A5_0000;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1;
  logic pipeValid = 1'b0, auxValid = 1'b0;
  logic [4:0] pipeAddr = '0, auxAddr = '0, q1Addr = '0, q2Addr = '0;
  logic [31:0] pipeData = '0, auxData = '0;
  logic auxReady, wrEnable, q1Busy, q2Busy, orderErr;
  logic [4:0] wrAddr;
  logic [31:0] wrData;
  int nCompared = 0, nMismatched = 0;
  wr_t mq[$];
  wr_t expQ[$];
  logic mEn = 1'b0, mAux = 1'b0, mErr = 1'b0, accepted;
  logic [4:0] mAddr = '0;
  int idx;

  register_writeback_queue #(.DEPTH(DEPTH), .RESET(RESET)) dut (
    .clk(clk), .rst(rst),
    .pipeValid(pipeValid), .pipeAddr(pipeAddr), .pipeData(pipeData),
    .auxValid(auxValid), .auxReady(auxReady), .auxAddr(auxAddr), .auxData(auxData),
    .wrAddr(wrAddr), .wrData(wrData), .wrEnable(wrEnable),
    .q1Addr(q1Addr), .q2Addr(q2Addr), .q1Busy(q1Busy), .q2Busy(q2Busy), .orderErr(orderErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic inModel(input logic [4:0] a);
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mBusy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return inModel(a) || (mEn && mAux && mAddr == a);
  endfunction

  task automatic modelReset();
    mq.delete();
    expQ.delete();
    mEn = 1'b0;
    mAux = 1'b0;
    mErr = 1'b0;
  endtask

  // one clock of stimulus: predict, push expectation, clock, then compare
  task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic pr, xf;
    wr_t w;
    pipeValid = pv; pipeAddr = pa; pipeData = pd;
    auxValid = av; auxAddr = aa; auxData = ad;
    #1;
    check("auxReady", auxReady, mq.size() < DEPTH);
    pr = pv && pa != 5'd0;
    xf = av && mq.size() < DEPTH;
    accepted = xf;
    if (pr && inModel(pa)) mErr = 1'b1;
    mEn = 1'b1;
    w = '0;
    if (pr) begin w = {pa, pd}; mAux = 1'b0; end
    else if (mq.size() != 0) begin w = mq.pop_front(); mAux = 1'b1; end
    else if (xf && aa != 5'd0) begin w = {aa, ad}; mAux = 1'b1; xf = 1'b0; end
    else mEn = 1'b0;
    if (xf && aa != 5'd0) mq.push_back({aa, ad});
    if (mEn) begin expQ.push_back(w); mAddr = w.a; end
    @(posedge clk);
    #1;
    check("wrEnable", wrEnable, mEn);
    if (wrEnable) begin
      if (expQ.size() == 0) check("unexpectedWrite", 1, 0);
      else begin
        w = expQ.pop_front();
        check("wrAddr", wrAddr, w.a);
        check("wrData", wrData, w.d);
      end
    end
    check("q1Busy", q1Busy, mBusy(q1Addr));
    check("q2Busy", q2Busy, mBusy(q2Addr));
    check("orderErr", orderErr, mErr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rstWrEnable", wrEnable, 0);
    check("rstWrAddr", wrAddr, 0);
    check("rstWrData", wrData, RESET);
    check("rstOrderErr", orderErr, 0);
    check("rstAuxReady", auxReady, 0);
    rst = 1'b0;
    #1;
    check("postRstAuxReady", auxReady, 1);
    @(posedge clk);
    #1;

    // async reset with three aux entries queued behind pipe writes
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hA1);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hA2);
    #2;
    rst = 1'b1;
    #1;
    check("midRstWrEnable", wrEnable, 0);
    check("midRstWrData", wrData, RESET);
    check("midRstAuxReady", auxReady, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1Addr = 5'd10;
    q2Addr = 5'd12;
    #1;
    check("relAuxReady", auxReady, 1);
    check("relBusy1", q1Busy, 0);
    check("relBusy2", q2Busy, 0);
    idle(2);

    // uncontended aux bypass
    q1Addr = 5'd5;
    q2Addr = 5'd0;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle(2);

    // pipe priority, aux order r8 then r9
    q1Addr = 5'd9;
    q2Addr = 5'd8;
    step(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h11);
    step(1'b1, 5'd2, 32'h102, 1'b1, 5'd9, 32'h22);
    step(1'b1, 5'd3, 32'h103, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'd0);
    idle(4);

    // fill to full under pipe pressure, then drain while wrapping pointers
    q1Addr = 5'd16;
    q2Addr = 5'd19;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 5'd2, $urandom, 1'b1, 5'(16 + idx), $urandom);
      if (accepted) idx++;
    end
    check("fullAuxReady", auxReady, 0);
    for (int c = 0; c < 40 && idx < 11; c++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + idx), $urandom);
      if (accepted) idx++;
    end
    idle(6);

    // r0 handling and sticky order error
    q1Addr = 5'd0;
    q2Addr = 5'd7;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h123);
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd2, 32'h66, 1'b1, 5'd7, 32'h77);
    step(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0);
    idle(4);
    check("stickyOrderErr", orderErr, 1);
    rst = 1'b1;
    #1;
    check("rstClearsOrderErr", orderErr, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
